// File: rtl/bp_pht_sched_pkg.sv
// Shared types for the PHT update scheduler.
// Counter, FSM state, update entry, saturating update.
package bp_pht_sched_pkg;

  localparam int MAX_IDX_W = 16;

  typedef logic [1:0] ctr_t;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_UPD_WR
  } state_e;

  typedef struct packed {
    logic [MAX_IDX_W-1:0] idx;
    logic                 taken;
  } upd_entry_t;

  function automatic ctr_t sat_update(
    input ctr_t ctr,
    input logic taken
  );
    ctr_t r;
    if (taken) begin
      r = (ctr == 2'b11) ? ctr : ctr + 2'd1;
    end else begin
      r = (ctr == 2'b00) ? ctr : ctr - 2'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bp_pht_upd_fifo.sv
// Pending-update FIFO for the PHT scheduler.
// Power-of-two depth; pointers wrap naturally.
module bp_pht_upd_fifo
  import bp_pht_sched_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic       push_i,
  input  upd_entry_t din_i,
  input  logic       pop_i,
  output upd_entry_t head_o,
  output logic       full_o,
  output logic       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] cnt_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  upd_entry_t       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign cnt_o   = cnt_q;
  assign head_o  = mem_q[rd_ptr_q];

  // Next pointers and occupancy; push+pop leaves count unchanged
  always_comb begin
    do_push  = push_i & ~full_o;
    do_pop   = pop_i & ~empty_o;
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    cnt_d    = cnt_q + CNT_W'(do_push)
             - CNT_W'(do_pop);
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Entry storage, needs no reset
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

endmodule

// File: rtl/bp_pht_update_scheduler.sv
// PHT port scheduler: init sweep, lookups, and
// queued read-modify-write counter updates.
module bp_pht_update_scheduler
  import bp_pht_sched_pkg::*;
#(
  parameter int   IDX_W      = 8,
  parameter int   FIFO_DEPTH = 4,
  parameter ctr_t INIT_VAL   = 2'b01
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             lookup_v_i,
  input  logic [IDX_W-1:0] lookup_idx_i,
  output logic             lookup_ready_o,
  output logic             pred_v_o,
  output logic             pred_taken_o,
  input  logic             upd_v_i,
  input  logic [IDX_W-1:0] upd_idx_i,
  input  logic             upd_taken_i,
  output logic             upd_ready_o,
  output logic             ram_v_o,
  output logic             ram_w_o,
  output logic [IDX_W-1:0] ram_addr_o,
  output logic [1:0]       ram_wdata_o,
  input  logic [1:0]       ram_rdata_i,
  output logic             init_done_o
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] init_addr_q, init_addr_d;
  logic             init_done_q, init_done_d;
  logic             pred_v_q, pred_v_d;

  upd_entry_t       push_ent;
  upd_entry_t       head;
  logic [IDX_W-1:0] head_idx;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_push;
  logic             fifo_pop;
  logic [CNT_W-1:0] unused_cnt;
  logic             unused_head;

  logic             ram_v;
  logic             ram_w;

  assign push_ent.idx   = MAX_IDX_W'(upd_idx_i);
  assign push_ent.taken = upd_taken_i;
  assign head_idx       = head.idx[IDX_W-1:0];
  assign unused_head    = ^head.idx;

  assign upd_ready_o = init_done_q & ~fifo_full;
  assign fifo_push   = upd_v_i & upd_ready_o;

  bp_pht_upd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .push_i    (fifo_push),
    .din_i     (push_ent),
    .pop_i     (fifo_pop),
    .head_o    (head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .cnt_o     (unused_cnt)
  );

  // Port arbitration and next state
  always_comb begin
    state_d        = state_q;
    init_addr_d    = init_addr_q;
    init_done_d    = init_done_q;
    pred_v_d       = 1'b0;
    ram_v          = 1'b0;
    ram_w          = 1'b0;
    ram_addr_o     = '0;
    ram_wdata_o    = '0;
    lookup_ready_o = 1'b0;
    fifo_pop       = 1'b0;
    unique case (state_q)
      ST_INIT: begin
        ram_v       = 1'b1;
        ram_w       = 1'b1;
        ram_addr_o  = init_addr_q;
        ram_wdata_o = INIT_VAL;
        init_addr_d = init_addr_q + 1'b1;
        if (init_addr_q == '1) begin
          state_d     = ST_IDLE;
          init_done_d = 1'b1;
        end
      end
      ST_IDLE: begin
        if (fifo_full) begin
          ram_v      = 1'b1;
          ram_addr_o = head_idx;
          state_d    = ST_UPD_WR;
        end else begin
          lookup_ready_o = 1'b1;
          if (lookup_v_i) begin
            ram_v      = 1'b1;
            ram_addr_o = lookup_idx_i;
            pred_v_d   = 1'b1;
          end else if (!fifo_empty) begin
            ram_v      = 1'b1;
            ram_addr_o = head_idx;
            state_d    = ST_UPD_WR;
          end
        end
      end
      ST_UPD_WR: begin
        ram_v       = 1'b1;
        ram_w       = 1'b1;
        ram_addr_o  = head_idx;
        ram_wdata_o = sat_update(ram_rdata_i,
                                 head.taken);
        fifo_pop    = 1'b1;
        state_d     = ST_IDLE;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // RAM strobes drop the moment reset asserts
  assign ram_v_o = ram_v & reset_n_i;
  assign ram_w_o = ram_w & reset_n_i;

  assign pred_v_o     = pred_v_q;
  assign pred_taken_o = pred_v_q & ram_rdata_i[1];
  assign init_done_o  = init_done_q;

  // Control state registers
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= ST_INIT;
      init_addr_q <= '0;
      init_done_q <= 1'b0;
      pred_v_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
      init_done_q <= init_done_d;
      pred_v_q    <= pred_v_d;
    end
  end

endmodule

// File: tb/tb_bp_pht_update_scheduler.sv
// Directed bench for the PHT update scheduler.
// Small RAM model with a write log; IDX_W = 4.
module tb_bp_pht_update_scheduler;

  logic       clk_i = 1'b0;
  logic       reset_n_i;
  logic       lookup_v_i;
  logic [3:0] lookup_idx_i;
  logic       lookup_ready_o;
  logic       pred_v_o;
  logic       pred_taken_o;
  logic       upd_v_i;
  logic [3:0] upd_idx_i;
  logic       upd_taken_i;
  logic       upd_ready_o;
  logic       ram_v_o;
  logic       ram_w_o;
  logic [3:0] ram_addr_o;
  logic [1:0] ram_wdata_o;
  logic [1:0] ram_rdata_i;
  logic       init_done_o;

  int n_chk = 0;
  int n_fail = 0;

  logic [1:0] mem [16];
  logic [5:0] wlog [$];
  logic       bd_en = 1'b0;
  logic [3:0] bd_addr = '0;
  logic [1:0] bd_data = '0;

  bp_pht_update_scheduler #(
    .IDX_W      (4),
    .FIFO_DEPTH (4),
    .INIT_VAL   (2'b01)
  ) dut (
    .clk_i          (clk_i),
    .reset_n_i      (reset_n_i),
    .lookup_v_i     (lookup_v_i),
    .lookup_idx_i   (lookup_idx_i),
    .lookup_ready_o (lookup_ready_o),
    .pred_v_o       (pred_v_o),
    .pred_taken_o   (pred_taken_o),
    .upd_v_i        (upd_v_i),
    .upd_idx_i      (upd_idx_i),
    .upd_taken_i    (upd_taken_i),
    .upd_ready_o    (upd_ready_o),
    .ram_v_o        (ram_v_o),
    .ram_w_o        (ram_w_o),
    .ram_addr_o     (ram_addr_o),
    .ram_wdata_o    (ram_wdata_o),
    .ram_rdata_i    (ram_rdata_i),
    .init_done_o    (init_done_o)
  );

  always #5 clk_i = ~clk_i;

  // Single-port RAM model, registered read
  always @(posedge clk_i) begin
    if (bd_en) mem[bd_addr] <= bd_data;
    if (ram_v_o) begin
      if (ram_w_o) begin
        mem[ram_addr_o] <= ram_wdata_o;
        wlog.push_back({ram_addr_o, ram_wdata_o});
      end else begin
        ram_rdata_i <= mem[ram_addr_o];
      end
    end
  end

  task automatic backdoor(
    input logic [3:0] a,
    input logic [1:0] d
  );
    @(negedge clk_i);
    bd_en = 1'b1; bd_addr = a; bd_data = d;
    @(negedge clk_i);
    bd_en = 1'b0;
  endtask

  task automatic wait_writes(input int n);
    int k;
    k = 0;
    while (wlog.size() < n && k < 60) begin
      @(negedge clk_i);
      k++;
    end
    #1;
  endtask

  task automatic enqueue(
    input logic [3:0] idx,
    input logic       tk,
    input int         n
  );
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      upd_v_i = 1'b1; upd_idx_i = idx;
      upd_taken_i = tk;
      #1;
      n_chk++;
      if (upd_ready_o !== 1'b1) begin
        n_fail++;
        $display("FAIL enq_ready: got %b want 1",
                 upd_ready_o);
      end
    end
    @(negedge clk_i);
    upd_v_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_n_i = 1'b0;
    lookup_v_i = 0; lookup_idx_i = '0;
    upd_v_i = 0; upd_idx_i = '0; upd_taken_i = 0;
    #1;
    n_chk++;
    if ({ram_v_o, pred_v_o, lookup_ready_o,
         upd_ready_o, init_done_o} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_outs: got %b want 00000",
               {ram_v_o, pred_v_o, lookup_ready_o,
                upd_ready_o, init_done_o});
    end
    repeat (2) @(negedge clk_i);
  endtask

  task automatic test_init();
    @(negedge clk_i);
    reset_n_i = 1'b1;
    for (int c = 0; c < 16; c++) begin
      if (c != 0) @(negedge clk_i);
      #1;
      n_chk++;
      if ({ram_v_o, ram_w_o, ram_addr_o, ram_wdata_o,
           lookup_ready_o, upd_ready_o, init_done_o}
          !== {2'b11, 4'(c), 2'b01, 3'b000}) begin
        n_fail++;
        $display("FAIL init_c%0d: got v%b w%b a%h d%b lr%b ur%b dn%b",
                 c, ram_v_o, ram_w_o, ram_addr_o,
                 ram_wdata_o, lookup_ready_o,
                 upd_ready_o, init_done_o);
      end
    end
    @(negedge clk_i);
    #1;
    n_chk++;
    if ({init_done_o, ram_v_o, lookup_ready_o,
         upd_ready_o} !== 4'b1011) begin
      n_fail++;
      $display("FAIL init_end: got %b want 1011",
               {init_done_o, ram_v_o, lookup_ready_o,
                upd_ready_o});
    end
    n_chk++;
    if (wlog.size() != 16) begin
      n_fail++;
      $display("FAIL init_count: got %0d want 16",
               wlog.size());
    end
    wlog.delete();
  endtask

  task automatic test_lookup();
    backdoor(4'd6, 2'b10);
    @(negedge clk_i);
    lookup_v_i = 1; lookup_idx_i = 4'd5;
    #1;
    n_chk++;
    if ({lookup_ready_o, ram_v_o, ram_w_o,
         ram_addr_o, pred_v_o} !== {3'b110, 4'd5, 1'b0})
    begin
      n_fail++;
      $display("FAIL lk_issue: got lr%b v%b w%b a%h p%b",
               lookup_ready_o, ram_v_o, ram_w_o,
               ram_addr_o, pred_v_o);
    end
    @(negedge clk_i);
    lookup_idx_i = 4'd6;
    #1;
    n_chk++;
    if ({pred_v_o, pred_taken_o, ram_addr_o}
        !== {2'b10, 4'd6}) begin
      n_fail++;
      $display("FAIL lk_pred5: got p%b t%b a%h want p1 t0 a6",
               pred_v_o, pred_taken_o, ram_addr_o);
    end
    @(negedge clk_i);
    lookup_v_i = 0;
    #1;
    n_chk++;
    if ({pred_v_o, pred_taken_o} !== 2'b11) begin
      n_fail++;
      $display("FAIL lk_pred6: got %b want 11",
               {pred_v_o, pred_taken_o});
    end
    @(negedge clk_i);
    #1;
    n_chk++;
    if (pred_v_o !== 1'b0) begin
      n_fail++;
      $display("FAIL lk_idle: pred_v got %b want 0",
               pred_v_o);
    end
  endtask

  task automatic test_sat_taken();
    logic [5:0] e [3];
    e = '{{4'd5, 2'b10}, {4'd5, 2'b11},
          {4'd5, 2'b11}};
    wlog.delete();
    enqueue(4'd5, 1'b1, 3);
    wait_writes(3);
    n_chk++;
    if (wlog.size() != 3) begin
      n_fail++;
      $display("FAIL tk_count: got %0d want 3",
               wlog.size());
    end
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (i >= wlog.size() || wlog[i] !== e[i]) begin
        n_fail++;
        $display("FAIL tk_wr%0d: got %h want %h", i,
                 (i < wlog.size()) ? wlog[i] : 6'h3f,
                 e[i]);
      end
    end
    @(negedge clk_i);
    lookup_v_i = 1; lookup_idx_i = 4'd5;
    @(negedge clk_i);
    lookup_v_i = 0;
    #1;
    n_chk++;
    if ({pred_v_o, pred_taken_o} !== 2'b11) begin
      n_fail++;
      $display("FAIL tk_pred: got %b want 11",
               {pred_v_o, pred_taken_o});
    end
  endtask

  task automatic test_sat_not_taken();
    wlog.delete();
    enqueue(4'd7, 1'b0, 4);
    wait_writes(4);
    n_chk++;
    if (wlog.size() != 4) begin
      n_fail++;
      $display("FAIL nt_count: got %0d want 4",
               wlog.size());
    end
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (i >= wlog.size() ||
          wlog[i] !== {4'd7, 2'b00}) begin
        n_fail++;
        $display("FAIL nt_wr%0d: got %h want 1c", i,
                 (i < wlog.size()) ? wlog[i] : 6'h3f);
      end
    end
    @(negedge clk_i);
    lookup_v_i = 1; lookup_idx_i = 4'd7;
    @(negedge clk_i);
    lookup_v_i = 0;
    #1;
    n_chk++;
    if ({pred_v_o, pred_taken_o} !== 2'b10) begin
      n_fail++;
      $display("FAIL nt_pred: got %b want 10",
               {pred_v_o, pred_taken_o});
    end
  endtask

  task automatic test_fifo_full();
    logic [5:0] e [4];
    e = '{{4'd9, 2'b10}, {4'd9, 2'b11},
          {4'd9, 2'b11}, {4'd9, 2'b11}};
    wlog.delete();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      lookup_v_i = 1; lookup_idx_i = 4'd0;
      upd_v_i = 1; upd_idx_i = 4'd9; upd_taken_i = 1;
      #1;
      n_chk++;
      if ({upd_ready_o, lookup_ready_o, ram_w_o}
          !== 3'b110) begin
        n_fail++;
        $display("FAIL full_fill%0d: got %b want 110",
                 k, {upd_ready_o, lookup_ready_o,
                     ram_w_o});
      end
    end
    @(negedge clk_i);
    upd_v_i = 0;
    #1;
    n_chk++;
    if ({upd_ready_o, lookup_ready_o, ram_v_o,
         ram_w_o, ram_addr_o, pred_v_o}
        !== {4'b0010, 4'd9, 1'b1}) begin
      n_fail++;
      $display("FAIL full_rd: got ur%b lr%b v%b w%b a%h p%b",
               upd_ready_o, lookup_ready_o, ram_v_o,
               ram_w_o, ram_addr_o, pred_v_o);
    end
    @(negedge clk_i);
    #1;
    n_chk++;
    if ({upd_ready_o, lookup_ready_o, ram_v_o,
         ram_w_o, ram_addr_o, ram_wdata_o, pred_v_o}
        !== {4'b0011, 4'd9, 2'b10, 1'b0}) begin
      n_fail++;
      $display("FAIL full_wr: got ur%b lr%b v%b w%b a%h d%b p%b",
               upd_ready_o, lookup_ready_o, ram_v_o,
               ram_w_o, ram_addr_o, ram_wdata_o,
               pred_v_o);
    end
    @(negedge clk_i);
    #1;
    n_chk++;
    if ({upd_ready_o, lookup_ready_o, ram_v_o,
         ram_w_o, ram_addr_o} !== {4'b1110, 4'd0})
    begin
      n_fail++;
      $display("FAIL full_resume: got ur%b lr%b v%b w%b a%h",
               upd_ready_o, lookup_ready_o, ram_v_o,
               ram_w_o, ram_addr_o);
    end
    @(negedge clk_i);
    lookup_v_i = 0;
    #1;
    n_chk++;
    if ({pred_v_o, pred_taken_o} !== 2'b10) begin
      n_fail++;
      $display("FAIL full_pred: got %b want 10",
               {pred_v_o, pred_taken_o});
    end
    wait_writes(4);
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (i >= wlog.size() || wlog[i] !== e[i]) begin
        n_fail++;
        $display("FAIL full_wr%0d: got %h want %h", i,
                 (i < wlog.size()) ? wlog[i] : 6'h3f,
                 e[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] ia [4];
    logic       ta [4];
    logic [5:0] e  [4];
    ia = '{4'd10, 4'd11, 4'd12, 4'd13};
    ta = '{1'b1, 1'b0, 1'b1, 1'b1};
    e  = '{{4'd10, 2'b10}, {4'd11, 2'b00},
           {4'd12, 2'b10}, {4'd13, 2'b10}};
    wlog.delete();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      upd_v_i = 1; upd_idx_i = ia[i];
      upd_taken_i = ta[i];
      #1;
      if (i == 2) begin
        n_chk++;
        if ({ram_w_o, dut.u_fifo.cnt_o} !== 4'b1010)
        begin
          n_fail++;
          $display("FAIL b2b_pop: got w%b cnt%0d want w1 cnt2",
                   ram_w_o, dut.u_fifo.cnt_o);
        end
      end
      if (i == 3) begin
        n_chk++;
        if (dut.u_fifo.cnt_o !== 3'd2) begin
          n_fail++;
          $display("FAIL b2b_occ: got %0d want 2",
                   dut.u_fifo.cnt_o);
        end
      end
    end
    @(negedge clk_i);
    upd_v_i = 0;
    wait_writes(4);
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (i >= wlog.size() || wlog[i] !== e[i]) begin
        n_fail++;
        $display("FAIL b2b_wr%0d: got %h want %h", i,
                 (i < wlog.size()) ? wlog[i] : 6'h3f,
                 e[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    wlog.delete();
    @(negedge clk_i);
    upd_v_i = 1; upd_idx_i = 4'd14; upd_taken_i = 1;
    @(negedge clk_i);
    upd_v_i = 0;
    @(negedge clk_i);
    #1;
    n_chk++;
    if ({ram_v_o, ram_w_o, ram_addr_o}
        !== {2'b11, 4'd14}) begin
      n_fail++;
      $display("FAIL rst_updwr: got v%b w%b a%h",
               ram_v_o, ram_w_o, ram_addr_o);
    end
    reset_n_i = 1'b0;
    #1;
    n_chk++;
    if ({ram_v_o, upd_ready_o, lookup_ready_o,
         init_done_o, dut.u_fifo.cnt_o}
        !== 7'b0) begin
      n_fail++;
      $display("FAIL rst_async: got v%b ur%b lr%b dn%b cnt%0d",
               ram_v_o, upd_ready_o, lookup_ready_o,
               init_done_o, dut.u_fifo.cnt_o);
    end
    @(negedge clk_i);
    n_chk++;
    if (wlog.size() != 0) begin
      n_fail++;
      $display("FAIL rst_drop: got %0d writes want 0",
               wlog.size());
    end
    reset_n_i = 1'b1;
    #1;
    n_chk++;
    if ({ram_v_o, ram_w_o, ram_addr_o, ram_wdata_o}
        !== {2'b11, 4'd0, 2'b01}) begin
      n_fail++;
      $display("FAIL rst_restart: got v%b w%b a%h d%b",
               ram_v_o, ram_w_o, ram_addr_o,
               ram_wdata_o);
    end
    wait_writes(16);
    for (int c = 0; c < 16; c++) begin
      n_chk++;
      if (c >= wlog.size() ||
          wlog[c] !== {4'(c), 2'b01}) begin
        n_fail++;
        $display("FAIL rst_sweep%0d: got %h want %h", c,
                 (c < wlog.size()) ? wlog[c] : 6'h3f,
                 {4'(c), 2'b01});
      end
    end
    n_chk++;
    if (init_done_o !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_done: got %b want 1",
               init_done_o);
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_lookup();
    test_sat_taken();
    test_sat_not_taken();
    test_fifo_full();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
